// File: rtl/dice_tid_dispatcher_if.sv
// Launch / dispatch / retire signal bundle for dice_tid_dispatcher.
// DICE_DISP_PERF_EN adds the perf_stall_cycles / perf_block_cycles outputs.
interface dice_tid_dispatcher_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int II_WIDTH   = 4,
  parameter int OUT_WIDTH  = ADDR_WIDTH + 1
);
  logic                  launch_valid;
  logic                  launch_ready;
  logic [ADDR_WIDTH-1:0] launch_base;
  logic [OUT_WIDTH-1:0]  launch_count;
  logic [II_WIDTH-1:0]   cfg_ii;
  logic                  disp_valid;
  logic                  disp_ready;
  logic [ADDR_WIDTH-1:0] disp_tid;
  logic                  disp_last;
  logic                  retire_valid;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  retire_err;
`ifdef DICE_DISP_PERF_EN
  logic [31:0]           perf_stall_cycles;
  logic [31:0]           perf_block_cycles;
`endif

  modport master (
`ifdef DICE_DISP_PERF_EN
    output perf_stall_cycles, perf_block_cycles,
`endif
    input  launch_valid, launch_base, launch_count, cfg_ii, disp_ready, retire_valid, abort,
    output launch_ready, disp_valid, disp_tid, disp_last, busy, done, retire_err
  );

  modport slave (
`ifdef DICE_DISP_PERF_EN
    input  perf_stall_cycles, perf_block_cycles,
`endif
    output launch_valid, launch_base, launch_count, cfg_ii, disp_ready, retire_valid, abort,
    input  launch_ready, disp_valid, disp_tid, disp_last, busy, done, retire_err
  );
endinterface

// File: rtl/dice_tid_dispatcher.sv
// Issues thread IDs of one launched block at a programmable initiation interval and
// tracks outstanding threads until all retire. Optional DICE_DISP_PERF_EN adds perf counters.
module dice_tid_dispatcher #(
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int II_WIDTH   = 4,
  parameter int OUT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dice_tid_dispatcher_if.master bus
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_DRAIN = 2'd2} state_t;

  localparam logic [OUT_WIDTH-1:0] CNT_ZERO = {OUT_WIDTH{1'b0}};
  localparam logic [OUT_WIDTH-1:0] CNT_ONE  = {{(OUT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [II_WIDTH-1:0]  II_ZERO  = {II_WIDTH{1'b0}};
  localparam logic [II_WIDTH-1:0]  II_ONE   = {{(II_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [OUT_WIDTH:0]   DEPTH_W  = (OUT_WIDTH+1)'(DEPTH);

  // Thread ID = (base + idx) mod DEPTH; idx < DEPTH so one subtraction suffices.
  function automatic logic [ADDR_WIDTH-1:0] wrap_tid(input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [OUT_WIDTH-1:0]  idx);
    logic [OUT_WIDTH:0] sum;
    sum = {2'b00, base} + {1'b0, idx};
    if (sum >= DEPTH_W) begin
      sum = sum - DEPTH_W;
    end else begin
      sum = sum + {(OUT_WIDTH+1){1'b0}};
    end
    return ADDR_WIDTH'(sum);
  endfunction

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] base_r, base_s;
  logic [OUT_WIDTH-1:0]  count_r, count_s;
  logic [II_WIDTH-1:0]   ii_r, ii_s;
  logic [OUT_WIDTH-1:0]  idx_r, idx_s;
  logic [II_WIDTH-1:0]   gap_r, gap_s;
  logic [OUT_WIDTH-1:0]  out_r, out_s;
  logic                  valid_r, valid_s;
  logic [ADDR_WIDTH-1:0] tid_r, tid_s;
  logic                  last_r, last_s;
  logic                  done_r, done_s;
  logic                  err_r, err_s;
  logic                  hs_s;
  logic                  bad_ret_s;

  // Next-state, outstanding accounting and registered dispatch outputs
  always_comb begin
    state_s   = state_r;
    base_s    = base_r;
    count_s   = count_r;
    ii_s      = ii_r;
    idx_s     = idx_r;
    gap_s     = gap_r;
    valid_s   = valid_r;
    tid_s     = tid_r;
    last_s    = last_r;
    done_s    = 1'b0;
    err_s     = err_r;
    bad_ret_s = 1'b0;
    hs_s      = valid_r & bus.disp_ready;

    if (hs_s && !bus.retire_valid) begin
      out_s = out_r + CNT_ONE;
    end else if (!hs_s && bus.retire_valid) begin
      if (state_r == ST_IDLE || out_r == CNT_ZERO) begin
        bad_ret_s = 1'b1;
        out_s     = out_r;
      end else begin
        out_s = out_r - CNT_ONE;
      end
    end else begin
      out_s = out_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (bus.launch_valid) begin
          base_s  = bus.launch_base;
          count_s = bus.launch_count;
          ii_s    = (bus.cfg_ii == II_ZERO) ? II_ONE : bus.cfg_ii;
          idx_s   = CNT_ZERO;
          gap_s   = II_ZERO;
          err_s   = 1'b0;
          if (bus.launch_count != CNT_ZERO) begin
            state_s = ST_ISSUE;
            valid_s = 1'b1;
            tid_s   = bus.launch_base;
            last_s  = (bus.launch_count == CNT_ONE);
          end else begin
            done_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (hs_s) begin
          idx_s = idx_r + CNT_ONE;
          if (last_r) begin
            state_s = ST_DRAIN;
            valid_s = 1'b0;
            last_s  = 1'b0;
          end else if (ii_r == II_ONE) begin
            valid_s = 1'b1;
            tid_s   = wrap_tid(base_r, idx_s);
            last_s  = (idx_s == count_r - CNT_ONE);
          end else begin
            valid_s = 1'b0;
            last_s  = 1'b0;
            gap_s   = ii_r - II_ONE;
          end
        end else if (!valid_r) begin
          // Gap expires: present the next thread in the following cycle
          if (gap_r <= II_ONE) begin
            valid_s = 1'b1;
            gap_s   = II_ZERO;
            tid_s   = wrap_tid(base_r, idx_r);
            last_s  = (idx_r == count_r - CNT_ONE);
          end else begin
            gap_s = gap_r - II_ONE;
          end
        end else begin
          valid_s = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (out_s == CNT_ZERO) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
        last_s  = 1'b0;
        out_s   = CNT_ZERO;
      end
    endcase

    err_s = err_s | bad_ret_s;
  end

  // State registers; abort overrides every other update but keeps retire_err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      base_r  <= {ADDR_WIDTH{1'b0}};
      count_r <= CNT_ZERO;
      ii_r    <= II_ZERO;
      idx_r   <= CNT_ZERO;
      gap_r   <= II_ZERO;
      out_r   <= CNT_ZERO;
      valid_r <= 1'b0;
      tid_r   <= {ADDR_WIDTH{1'b0}};
      last_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else if (bus.abort) begin
      state_r <= ST_IDLE;
      idx_r   <= CNT_ZERO;
      gap_r   <= II_ZERO;
      out_r   <= CNT_ZERO;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      base_r  <= base_s;
      count_r <= count_s;
      ii_r    <= ii_s;
      idx_r   <= idx_s;
      gap_r   <= gap_s;
      out_r   <= out_s;
      valid_r <= valid_s;
      tid_r   <= tid_s;
      last_r  <= last_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  assign bus.launch_ready = (state_r == ST_IDLE);
  assign bus.busy         = (state_r != ST_IDLE);
  assign bus.disp_valid   = valid_r;
  assign bus.disp_tid     = tid_r;
  assign bus.disp_last    = last_r;
  assign bus.done         = done_r;
  assign bus.retire_err   = err_r;

`ifdef DICE_DISP_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] block_cnt_r;
  logic        launch_acc_s;

  assign launch_acc_s = (state_r == ST_IDLE) & bus.launch_valid & ~bus.abort;

  // Saturating stall / block-duration counters, frozen while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'd0;
      block_cnt_r <= 32'd0;
    end else if (launch_acc_s) begin
      stall_cnt_r <= 32'd0;
      block_cnt_r <= 32'd0;
    end else if (state_r != ST_IDLE) begin
      if (valid_r && !bus.disp_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (block_cnt_r != 32'hFFFF_FFFF) begin
        block_cnt_r <= block_cnt_r + 32'd1;
      end
    end
  end

  assign bus.perf_stall_cycles = stall_cnt_r;
  assign bus.perf_block_cycles = block_cnt_r;
`endif

endmodule

// File: tb/tb_dice_tid_dispatcher.sv
// Scoreboard bench for dice_tid_dispatcher: expected {tid,last} pairs are queued at launch
// and popped by a negedge monitor on every dispatch handshake.
module tb_dice_tid_dispatcher;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int OW    = 10;
  localparam int IW    = 4;

  logic clk;
  logic rst_n;

  dice_tid_dispatcher_if #(.ADDR_WIDTH(AW), .II_WIDTH(IW), .OUT_WIDTH(OW)) bus();

  dice_tid_dispatcher #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          done_cnt = 0;
  logic [AW:0] exp_q[$];
  int          hs_cyc[$];
  int          ret_due[$];
  bit          auto_retire = 1'b0;
  logic        retire_auto = 1'b0;
  logic        retire_manual = 1'b0;
  bit          prev_stall = 1'b0;
  logic [AW-1:0] prev_tid = '0;

  assign bus.retire_valid = retire_auto | retire_manual;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // cycle counter and auto-retire driver (retire 3 cycles after each issue)
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      retire_auto = 1'b0;
      if (ret_due.size() > 0 && ret_due[0] <= cyc) begin
        retire_auto = 1'b1;
        void'(ret_due.pop_front());
      end
    end
  end

  // scoreboard monitor
  initial begin
    logic [AW:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.done) done_cnt++;
      if (rst_n && bus.disp_valid && bus.disp_ready) begin
        hs_cyc.push_back(cyc);
        if (auto_retire) ret_due.push_back(cyc + 3);
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL disp_unexpected: got tid=%0d last=%0b, required no dispatch", bus.disp_tid, bus.disp_last);
        end else begin
          e = exp_q.pop_front();
          if ({bus.disp_tid, bus.disp_last} !== e) begin
            fails++;
            $display("FAIL disp_tid: got tid=%0d last=%0b, required tid=%0d last=%0b",
                     bus.disp_tid, bus.disp_last, e[AW:1], e[0]);
          end
        end
      end
      if (prev_stall) begin
        checks++;
        if (bus.disp_valid !== 1'b1 || bus.disp_tid !== prev_tid) begin
          fails++;
          $display("FAIL disp_hold: got valid=%0b tid=%0d, required valid=1 tid=%0d", bus.disp_valid, bus.disp_tid, prev_tid);
        end
      end
      prev_stall = rst_n && bus.disp_valid && !bus.disp_ready && !bus.abort;
      prev_tid   = bus.disp_tid;
    end
  end

  task automatic do_launch(input logic [AW-1:0] base, input int count, input int ii);
    for (int i = 0; i < count; i++)
      exp_q.push_back({AW'((int'(base) + i) % DEPTH), (i == count - 1)});
    bus.launch_valid = 1'b1;
    bus.launch_base  = base;
    bus.launch_count = OW'(count);
    bus.cfg_ii       = IW'(ii);
    @(posedge clk); #1;
    bus.launch_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit found, output int at);
    found = 1'b0;
    at = 0;
    for (int i = 0; i < budget && !found; i++) begin
      if (bus.done === 1'b1) begin
        found = 1'b1;
        at = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.launch_valid = 1'b0; bus.launch_base = '0; bus.launch_count = '0;
    bus.cfg_ii = '0; bus.disp_ready = 1'b1; bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.launch_ready, bus.disp_valid, bus.disp_last, bus.busy, bus.done, bus.retire_err} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_flags: got rdy/val/last/busy/done/err=%b, required 100000",
               {bus.launch_ready, bus.disp_valid, bus.disp_last, bus.busy, bus.done, bus.retire_err});
    end
    checks++;
    if (bus.disp_tid !== 9'd0) begin
      fails++; $display("FAIL reset_tid: got %0d, required 0", bus.disp_tid);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.launch_ready !== 1'b1 || bus.busy !== 1'b0 || bus.disp_valid !== 1'b0) begin
      fails++; $display("FAIL post_reset_idle: got ready=%0b busy=%0b valid=%0b, required 1 0 0",
                        bus.launch_ready, bus.busy, bus.disp_valid);
    end
  endtask

  task automatic test_basic();
    int n0, a, at;
    bit found;
    auto_retire = 1'b1;
    bus.disp_ready = 1'b1;
    checks++;
    if (bus.launch_ready !== 1'b1) begin fails++; $display("FAIL basic_ready: got %0b, required 1", bus.launch_ready); end
    n0 = hs_cyc.size();
    do_launch(9'd0, 4, 1);
    a = cyc;
    checks++;
    if (bus.disp_valid !== 1'b1 || bus.busy !== 1'b1) begin
      fails++; $display("FAIL basic_latency: got valid=%0b busy=%0b, required 1 1", bus.disp_valid, bus.busy);
    end
    wait_done(60, found, at);
    checks++;
    if (!found) begin fails++; $display("FAIL basic_done_timeout: got no done, required done"); end
    checks++;
    if (hs_cyc.size() - n0 != 4) begin
      fails++; $display("FAIL basic_count: got %0d issues, required 4", hs_cyc.size() - n0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (hs_cyc[n0+i] != a + i) begin
          fails++; $display("FAIL basic_spacing: issue %0d at cycle %0d, required %0d", i, hs_cyc[n0+i], a + i);
        end
      end
      checks++;
      if (found && at != hs_cyc[n0+3] + 4) begin
        fails++; $display("FAIL basic_done_cycle: got %0d, required %0d", at, hs_cyc[n0+3] + 4);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL basic_done_pulse: got done=%0b busy=%0b, required 0 0", bus.done, bus.busy);
    end
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL basic_leftover: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    int n0, a, at;
    bit found;
    auto_retire = 1'b1;
    n0 = hs_cyc.size();
    do_launch(9'd510, 4, 3);
    a = cyc;
    wait_done(80, found, at);
    checks++;
    if (!found) begin fails++; $display("FAIL wrap_done_timeout: got no done, required done"); end
    checks++;
    if (hs_cyc.size() - n0 != 4) begin
      fails++; $display("FAIL wrap_count: got %0d issues, required 4", hs_cyc.size() - n0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (hs_cyc[n0+i] != a + 3*i) begin
          fails++; $display("FAIL wrap_ii: issue %0d at cycle %0d, required %0d", i, hs_cyc[n0+i], a + 3*i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n0, a, at;
    bit found;
    auto_retire = 1'b1;
    @(posedge clk); #1;
    n0 = hs_cyc.size();
    do_launch(9'd0, 3, 1);
    a = cyc;
    @(posedge clk); #1;
    bus.disp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.disp_valid !== 1'b1 || bus.disp_tid !== 9'd1) begin
        fails++; $display("FAIL stall_hold: got valid=%0b tid=%0d, required 1 1", bus.disp_valid, bus.disp_tid);
      end
      @(posedge clk); #1;
    end
    bus.disp_ready = 1'b1;
    wait_done(60, found, at);
    checks++;
    if (!found) begin fails++; $display("FAIL stall_done_timeout: got no done, required done"); end
    checks++;
    if (hs_cyc.size() - n0 != 3) begin
      fails++; $display("FAIL stall_count: got %0d issues, required 3", hs_cyc.size() - n0);
    end else begin
      checks++;
      if (hs_cyc[n0+1] != a + 6 || hs_cyc[n0+2] != a + 7) begin
        fails++; $display("FAIL stall_timing: got %0d,%0d, required %0d,%0d", hs_cyc[n0+1], hs_cyc[n0+2], a + 6, a + 7);
      end
    end
  endtask

  task automatic test_zero_count();
    int n0, d0;
    @(posedge clk); #1;
    n0 = hs_cyc.size();
    d0 = done_cnt;
    do_launch(9'd7, 0, 1);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.disp_valid !== 1'b0) begin
      fails++; $display("FAIL zero_done: got done=%0b busy=%0b valid=%0b, required 1 0 0", bus.done, bus.busy, bus.disp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL zero_pulse: got done=%0b busy=%0b, required 0 0", bus.done, bus.busy);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (hs_cyc.size() != n0 || done_cnt - d0 != 1) begin
      fails++; $display("FAIL zero_counts: got issues=%0d dones=%0d, required 0 1", hs_cyc.size() - n0, done_cnt - d0);
    end
  endtask

  task automatic test_abort();
    int n0, d0, b;
    auto_retire = 1'b0;
    ret_due.delete();
    bus.disp_ready = 1'b1;
    @(posedge clk); #1;
    n0 = hs_cyc.size();
    d0 = done_cnt;
    do_launch(9'd40, 8, 1);
    repeat (3) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    bus.disp_ready = 1'b0;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    checks++;
    if (bus.disp_valid !== 1'b0 || bus.disp_last !== 1'b0 || bus.busy !== 1'b0 || bus.launch_ready !== 1'b1) begin
      fails++; $display("FAIL abort_idle: got valid=%0b last=%0b busy=%0b ready=%0b, required 0 0 0 1",
                        bus.disp_valid, bus.disp_last, bus.busy, bus.launch_ready);
    end
    checks++;
    if (hs_cyc.size() - n0 != 3 || exp_q.size() != 5) begin
      fails++; $display("FAIL abort_issued: got issued=%0d pending=%0d, required 3 5", hs_cyc.size() - n0, exp_q.size());
    end
    exp_q.delete();
    bus.disp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0 || bus.retire_err !== 1'b0) begin
      fails++; $display("FAIL abort_no_done: got dones=%0d err=%0b, required 0 0", done_cnt - d0, bus.retire_err);
    end
    do_launch(9'd100, 1, 1);
    b = cyc;
    checks++;
    if (bus.disp_valid !== 1'b1 || bus.disp_tid !== 9'd100 || bus.disp_last !== 1'b1) begin
      fails++; $display("FAIL relaunch: got valid=%0b tid=%0d last=%0b at cycle %0d, required 1 100 1",
                        bus.disp_valid, bus.disp_tid, bus.disp_last, b);
    end
    @(posedge clk); #1;
    retire_manual = 1'b1;
    @(posedge clk); #1;
    retire_manual = 1'b0;
    checks++;
    if (bus.done !== 1'b1) begin fails++; $display("FAIL relaunch_done: got %0b, required 1", bus.done); end
  endtask

  task automatic test_retire_err();
    auto_retire = 1'b0;
    bus.disp_ready = 1'b1;
    @(posedge clk); #1;
    retire_manual = 1'b1;
    @(posedge clk); #1;
    retire_manual = 1'b0;
    checks++;
    if (bus.retire_err !== 1'b1) begin fails++; $display("FAIL err_set: got %0b, required 1", bus.retire_err); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.retire_err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %0b, required 1", bus.retire_err); end
    do_launch(9'd200, 2, 1);
    checks++;
    if (bus.retire_err !== 1'b0) begin fails++; $display("FAIL err_clear: got %0b, required 0", bus.retire_err); end
    retire_manual = 1'b1;
    @(posedge clk); #1;
    retire_manual = 1'b0;
    checks++;
    if (bus.retire_err !== 1'b0) begin fails++; $display("FAIL err_same_cycle: got %0b, required 0", bus.retire_err); end
    @(posedge clk); #1;
    retire_manual = 1'b1;
    @(posedge clk); #1;
    retire_manual = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.retire_err !== 1'b0) begin
      fails++; $display("FAIL err_outstanding: got done=%0b err=%0b, required 1 0", bus.done, bus.retire_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_count();
    test_abort();
    test_retire_err();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/dice_tid_dispatcher.md
Name: dice_tid_dispatcher

Overview:
Sequences thread IDs into the CGRA register-file address path for one launched block. Accepts a launch of (base, count), issues one disp_tid per handshake at a configurable initiation interval, and tracks outstanding threads until all retire. Sits between the CGRA block scheduler and the per-bank RF address generation; disp_tid drives the bank address converter directly.

Parameters:
DEPTH, 512, RF entries per bank; thread-ID space, wraps modulo DEPTH
ADDR_WIDTH, $clog2(DEPTH), thread-ID / RF address width
II_WIDTH, 4, width of initiation-interval config
OUT_WIDTH, ADDR_WIDTH+1, outstanding/count counter width (represents 0..DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
launch_valid  in  1  launch request
launch_ready  out  1  high in IDLE only
launch_base  in  ADDR_WIDTH  first thread ID
launch_count  in  OUT_WIDTH  threads to issue, 0..DEPTH
cfg_ii  in  II_WIDTH  min cycles between issues; sampled at launch accept
disp_valid  out  1  disp_tid valid
disp_ready  in  1  downstream accepts
disp_tid  out  ADDR_WIDTH  thread ID to RF address converter
disp_last  out  1  marks final thread of block
retire_valid  in  1  one thread completed (pulse per thread)
abort  in  1  synchronous kill of current block
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: all threads issued and retired
retire_err  out  1  sticky: retire seen with zero outstanding

Behaviour:
- Reset: state IDLE, disp_valid=0, disp_tid=0, disp_last=0, busy=0, done=0, retire_err=0, launch_ready=1, all counters 0.
- States IDLE, ISSUE, DRAIN.
- IDLE: launch_ready=1. On launch_valid: latch base, count, ii=max(cfg_ii,1); clear idx, gap counter, retire_err. count!=0 -> ISSUE; count==0 -> done pulse next cycle, stay IDLE, no disp.
- ISSUE: disp_valid=1 when gap counter==0. disp_tid=(base+idx) mod DEPTH, disp_last=(idx==count-1). disp_valid/tid/last registered, held stable while disp_valid && !disp_ready.
- Handshake (disp_valid && disp_ready): idx++, outstanding++, gap counter=ii-1; disp_valid drops for ii-1 cycles (ii=1 -> back-to-back every cycle). On last handshake -> DRAIN, disp_valid=0 next cycle.
- First disp_valid asserts the cycle after launch accept (latency 1).
- Outstanding: +1 on handshake, -1 on retire_valid, unchanged when both same cycle. retire_valid with outstanding==0 and no same-cycle handshake: ignored, retire_err<=1.
- retire_valid accepted in ISSUE and DRAIN; ignored (sets retire_err) in IDLE.
- DRAIN: when next-outstanding==0 (including retire in this cycle) -> IDLE, done=1 for exactly one cycle at that edge. launch may be accepted in the done cycle.
- abort (any state, priority over all else): next cycle IDLE, disp_valid=0, disp_last=0, outstanding=0, idx=0; no done pulse; retire_err unchanged.
- Thread-ID wrap: base=DEPTH-2, count=4 -> DEPTH-2, DEPTH-1, 0, 1.
- rst_n assertion mid-block: immediate return to reset values, no done.

Optional Feature:
DICE_DISP_PERF_EN: adds outputs perf_stall_cycles (32b, cycles with disp_valid && !disp_ready) and perf_block_cycles (32b, launch accept to done); both cleared on launch accept and reset, saturate at all-ones, frozen in IDLE. Without macro: ports and counters absent, other behaviour identical.

Test Plan:
- Launch base=0,count=4,cfg_ii=1, disp_ready=1, retire each thread 3 cycles after issue -> tids 0,1,2,3 on consecutive cycles, disp_last on tid 3, done one cycle after 4th retire.
- Launch base=510,count=4,cfg_ii=3, ready=1 -> tids 510,511,0,1, each separated by 2 idle cycles.
- Launch count=3, disp_ready low 5 cycles on 2nd thread -> disp_tid=1 held stable 5 cycles, no duplicate, no skip.
- Launch count=0 -> no disp_valid, done pulse exactly one cycle after accept, busy stays 0.
- Launch count=8, abort after 3 issues -> disp_valid 0 next cycle, IDLE, no done; new launch base=100,count=1 issues tid 100.
- retire_valid in IDLE -> retire_err=1, held until next launch accept; retire+handshake same cycle leaves outstanding unchanged.
